// File: rtl/io_bus_fabric.sv
// Routes one core load/store port to N_SLOTS memory-mapped slaves with ready handshake,
// registered read return and fault reporting. Optional access timeout: BUS_TIMEOUT_EN.
module io_bus_fabric #(
   parameter int          N_SLOTS     = 4,
   parameter int          SLOT_LSB    = 12,
   parameter int          SLOT_W      = 4,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            m_addr,
   input  logic [31:0]            m_wd,
   input  logic                   m_we,
   input  logic                   m_re,
   input  logic [1:0]             m_ctrl,
   output logic [31:0]            m_rd,
   output logic                   m_ready,
   output logic                   m_fault,
   output logic [7:0]             fault_cnt,
   output logic [N_SLOTS-1:0]     s_sel,
   output logic                   s_we,
   output logic [31:0]            s_addr,
   output logic [31:0]            s_wd,
   output logic [1:0]             s_ctrl,
   input  logic [32*N_SLOTS-1:0]  s_rd,
   input  logic [N_SLOTS-1:0]     s_ready
);

   // state  | meaning
   // IDLE   | waiting for m_we/m_re, decodes slot
   // ACCESS | slave selected, waiting for its ready
   // RESP   | one-cycle m_ready pulse (m_fault qualifies it)
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [31:0] OFF_MASK = (32'd1 << SLOT_LSB) - 32'd1;

   state_t               state, state_nxt;
   logic [31:0]          m_rd_nxt, s_addr_nxt, s_wd_nxt, rd_sel;
   logic                 m_ready_nxt, m_fault_nxt, s_we_nxt, rdy, slot_ok;
   logic [7:0]           fault_cnt_nxt;
   logic [N_SLOTS-1:0]   s_sel_nxt, dec;
   logic [1:0]           s_ctrl_nxt;
   logic [SLOT_W-1:0]    slot;
   logic                 addr_unused;

`ifdef BUS_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
`endif

   assign slot        = m_addr[SLOT_LSB +: SLOT_W];
   assign slot_ok     = 32'(slot) < 32'(N_SLOTS);
   assign rdy         = |(s_ready & s_sel);
   assign addr_unused = ^m_addr;

   always_comb begin
      dec    = '0;
      rd_sel = '0;
      for (int k = 0; k < N_SLOTS; k++) begin
         dec[k] = (32'(slot) == 32'(k));
         if (s_sel[k]) rd_sel = rd_sel | s_rd[32*k +: 32];
      end
   end

   always_comb begin
      state_nxt     = state;
      m_rd_nxt      = m_rd;
      m_ready_nxt   = 1'b0;
      m_fault_nxt   = 1'b0;
      fault_cnt_nxt = fault_cnt;
      s_sel_nxt     = s_sel;
      s_we_nxt      = s_we;
      s_addr_nxt    = s_addr;
      s_wd_nxt      = s_wd;
      s_ctrl_nxt    = s_ctrl;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt_nxt   = tmo_cnt;
`endif
      unique case (state)
         IDLE: begin
            if (m_we || m_re) begin
               s_addr_nxt = m_addr & OFF_MASK;
               s_wd_nxt   = m_wd;
               s_ctrl_nxt = m_ctrl;
               if (slot_ok) begin
                  s_sel_nxt = dec;
                  s_we_nxt  = m_we;
                  state_nxt = ACCESS;
`ifdef BUS_TIMEOUT_EN
                  tmo_cnt_nxt = '0;
`endif
               end else begin
                  // unmapped slot: nothing is selected, the write is dropped
                  m_ready_nxt = 1'b1;
                  m_fault_nxt = 1'b1;
                  m_rd_nxt    = ERR_DATA;
                  if (fault_cnt != 8'hFF) fault_cnt_nxt = fault_cnt + 8'd1;
                  state_nxt   = RESP;
               end
            end
         end
         ACCESS: begin
            if (rdy) begin
               m_rd_nxt    = rd_sel;
               s_sel_nxt   = '0;
               s_we_nxt    = 1'b0;
               m_ready_nxt = 1'b1;
               state_nxt   = RESP;
            end
`ifdef BUS_TIMEOUT_EN
            else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
               s_sel_nxt   = '0;
               s_we_nxt    = 1'b0;
               m_ready_nxt = 1'b1;
               m_fault_nxt = 1'b1;
               m_rd_nxt    = ERR_DATA;
               if (fault_cnt != 8'hFF) fault_cnt_nxt = fault_cnt + 8'd1;
               state_nxt   = RESP;
            end else begin
               tmo_cnt_nxt = tmo_cnt + 1'b1;
            end
`endif
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         m_rd      <= '0;
         m_ready   <= 1'b0;
         m_fault   <= 1'b0;
         fault_cnt <= '0;
         s_sel     <= '0;
         s_we      <= 1'b0;
         s_addr    <= '0;
         s_wd      <= '0;
         s_ctrl    <= '0;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         state     <= state_nxt;
         m_rd      <= m_rd_nxt;
         m_ready   <= m_ready_nxt;
         m_fault   <= m_fault_nxt;
         fault_cnt <= fault_cnt_nxt;
         s_sel     <= s_sel_nxt;
         s_we      <= s_we_nxt;
         s_addr    <= s_addr_nxt;
         s_wd      <= s_wd_nxt;
         s_ctrl    <= s_ctrl_nxt;
`ifdef BUS_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_io_bus_fabric.sv
// Directed bench for io_bus_fabric: expected responses queued at request time and
// compared when m_ready pulses. Covers the BUS_TIMEOUT_EN build when that macro is set.
module tb_io_bus_fabric;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     m_addr, m_wd, m_rd, s_addr, s_wd;
   logic            m_we, m_re, m_ready, m_fault, s_we;
   logic [1:0]      m_ctrl, s_ctrl;
   logic [7:0]      fault_cnt;
   logic [N-1:0]    s_sel, s_ready;
   logic [32*N-1:0] s_rd;

   int errors = 0;
   int checks = 0;
   int lat;

   typedef struct {
      logic [31:0] rd;
      logic        fault;
      logic        chk_rd;
   } exp_t;
   exp_t sbq[$];

   io_bus_fabric #(
      .N_SLOTS(N), .SLOT_LSB(12), .SLOT_W(4), .TIMEOUT_CYC(8), .ERR_DATA(32'hDEAD_BEEF)
   ) dut (
      .clk(clk), .rst(rst), .m_addr(m_addr), .m_wd(m_wd), .m_we(m_we), .m_re(m_re),
      .m_ctrl(m_ctrl), .m_rd(m_rd), .m_ready(m_ready), .m_fault(m_fault),
      .fault_cnt(fault_cnt), .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
      .s_ctrl(s_ctrl), .s_rd(s_rd), .s_ready(s_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic req(input logic we, input logic re, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] ctrl,
                      input logic [31:0] erd, input logic efault, input logic echk);
      exp_t e;
      m_we = we; m_re = re; m_addr = addr; m_wd = wd; m_ctrl = ctrl;
      e.rd = erd; e.fault = efault; e.chk_rd = echk;
      sbq.push_back(e);
   endtask

   task automatic wait_resp(input int budget, output int l);
      exp_t e;
      l = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         l++;
         if (m_ready === 1'b1) break;
      end
      m_we = 1'b0; m_re = 1'b0;
      chk("resp_seen", 32'(m_ready), 32'd1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (m_ready === 1'b1) begin
            chk("m_fault", 32'(m_fault), 32'(e.fault));
            if (e.chk_rd) chk("m_rd", m_rd, e.rd);
         end
      end
      tick();
      chk("ready_one_cycle", 32'(m_ready), 32'd0);
   endtask

   initial begin
      rst = 1'b1; m_addr = '0; m_wd = '0; m_we = 1'b0; m_re = 1'b0; m_ctrl = '0;
      s_ready = '0;
      s_rd = {32'h3333_0003, 32'h2222_0002, 32'h1234_5678, 32'hCAFE_0000};
      tick(); tick();
      chk("rst_s_sel", 32'(s_sel), 32'd0);
      chk("rst_s_we", 32'(s_we), 32'd0);
      chk("rst_s_addr", s_addr, 32'd0);
      chk("rst_m_rd", m_rd, 32'd0);
      chk("rst_m_ready", 32'(m_ready), 32'd0);
      chk("rst_m_fault", 32'(m_fault), 32'd0);
      chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
      rst = 1'b0;

      // read slot 1
      s_ready = 4'b0010;
      req(1'b0, 1'b1, 32'h0000_1004, 32'h0, 2'b10, 32'h1234_5678, 1'b0, 1'b1);
      tick();
      chk("rd1_s_sel", 32'(s_sel), 32'h2);
      chk("rd1_s_addr", s_addr, 32'h4);
      chk("rd1_s_we", 32'(s_we), 32'd0);
      wait_resp(10, lat);
      chk("rd1_latency", lat + 1, 2);

      // write slot 2 with 3 wait states; other slots' ready must be ignored
      s_ready = 4'b1011;
      req(1'b1, 1'b0, 32'h0000_2010, 32'h0000_00A5, 2'b00, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wr2_s_sel", 32'(s_sel), 32'h4);
         chk("wr2_s_we", 32'(s_we), 32'd1);
         chk("wr2_s_wd", s_wd, 32'hA5);
         chk("wr2_no_ready", 32'(m_ready), 32'd0);
      end
      chk("wr2_s_addr", s_addr, 32'h10);
      chk("wr2_s_ctrl", 32'(s_ctrl), 32'd0);
      s_ready = 4'b1111;
      wait_resp(10, lat);
      chk("wr2_resp_lat", lat, 1);

      // reads of slot 0 and slot 3 exercise the return mux
      req(1'b0, 1'b1, 32'h0000_0000, 32'h0, 2'b01, 32'hCAFE_0000, 1'b0, 1'b1);
      wait_resp(10, lat);
      chk("rd0_latency", lat, 2);
      req(1'b0, 1'b1, 32'h0000_3FFC, 32'h0, 2'b10, 32'h3333_0003, 1'b0, 1'b1);
      wait_resp(10, lat);
      chk("rd3_latency", lat, 2);

      // unmapped slot 7
      req(1'b0, 1'b1, 32'h0000_7000, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
      wait_resp(10, lat);
      chk("flt_latency", lat, 1);
      chk("flt_s_sel", 32'(s_sel), 32'd0);
      chk("flt_cnt1", 32'(fault_cnt), 32'd1);

      for (int i = 0; i < 254; i++) begin
         req(1'b1, 1'b0, 32'h0000_F000, 32'h55, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
         wait_resp(10, lat);
      end
      chk("flt_cnt255", 32'(fault_cnt), 32'hFF);
      for (int i = 0; i < 2; i++) begin
         req(1'b0, 1'b1, 32'h0000_4000, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
         wait_resp(10, lat);
      end
      chk("flt_cnt_sat", 32'(fault_cnt), 32'hFF);

      // both strobes to slot 3: write wins
      s_ready = 4'b0000;
      req(1'b1, 1'b1, 32'h0000_3008, 32'h1111_2222, 2'b10, 32'h0, 1'b0, 1'b0);
      tick();
      chk("prio_s_sel", 32'(s_sel), 32'h8);
      chk("prio_s_we", 32'(s_we), 32'd1);
      s_ready = 4'b1000;
      wait_resp(10, lat);

      // slot 0 never ready
      s_ready = 4'b0000;
`ifdef BUS_TIMEOUT_EN
      req(1'b0, 1'b1, 32'h0000_0ABC, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1, 1'b1);
      wait_resp(20, lat);
      chk("tmo_latency", lat, 9);
      chk("tmo_s_sel", 32'(s_sel), 32'd0);
      m_we = 1'b0; m_re = 1'b1; m_addr = 32'h0000_0ABC;
      tick(); tick();
`else
      m_we = 1'b0; m_re = 1'b1; m_addr = 32'h0000_0ABC;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (m_ready !== 1'b0) chk("hang_no_ready", 32'(m_ready), 32'd0);
      end
      chk("hang_waiting", 32'(m_ready), 32'd0);
`endif
      chk("hang_s_sel", 32'(s_sel), 32'h1);

      // reset in the middle of the access
      rst = 1'b1;
      tick();
      m_re = 1'b0;
      chk("mid_rst_s_sel", 32'(s_sel), 32'd0);
      chk("mid_rst_s_addr", s_addr, 32'd0);
      chk("mid_rst_m_ready", 32'(m_ready), 32'd0);
      chk("mid_rst_fault_cnt", 32'(fault_cnt), 32'd0);
      chk("mid_rst_m_rd", m_rd, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post_rst_quiet", 32'(m_ready), 32'd0);
      end

      s_ready = 4'b0010;
      req(1'b0, 1'b1, 32'h0000_1FF0, 32'h0, 2'b10, 32'h1234_5678, 1'b0, 1'b1);
      wait_resp(10, lat);
      chk("post_rst_latency", lat, 2);
      chk("post_rst_s_addr", s_addr, 32'hFF0);
      chk("sb_empty", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
